// File: rtl/ram_bus_master.sv
// ram_bus_master: single-command initiator for a cs/we/oe RAM with a shared
// bidirectional data bus. One read or write is accepted through a valid/ready
// handshake, the RAM strobes are sequenced from registers, and completion is
// signalled by a one-cycle done pulse.
// Optional build macro: RAM_BUS_MASTER_TURNAROUND_EN adds a TURN state that
// leaves one dead bus cycle after every read before the next command.
module ram_bus_master #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req,
  output logic                  ready,
  input  logic                  wr,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  done,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  inout  wire  [DATA_WIDTH-1:0] ram_data
);

`ifdef RAM_BUS_MASTER_TURNAROUND_EN
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR       = 3'd1,
    RD_ISSUE = 3'd2,
    RD_CAPT  = 3'd3,
    TURN     = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR       = 3'd1,
    RD_ISSUE = 3'd2,
    RD_CAPT  = 3'd3
  } state_t;
`endif

  state_t                state;
  logic                  drive_en;
  logic [DATA_WIDTH-1:0] wdata_q;

  // ready is a pure decode of the state register so a command can be
  // accepted in the same cycle that the previous done is high.
  assign ready = (state == IDLE);

  // The bus is driven only from the registered enable, which is set solely
  // for the WR state; ram_oe is never high in WR, so ownership is exclusive.
  assign ram_data = drive_en ? wdata_q : {DATA_WIDTH{1'bz}};

  // Command sequencer: state, RAM strobes, bus enable, read capture and done.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ram_cs   <= 1'b0;
      ram_we   <= 1'b0;
      ram_oe   <= 1'b0;
      ram_addr <= {ADDR_WIDTH{1'b0}};
      rdata    <= {DATA_WIDTH{1'b0}};
      done     <= 1'b0;
      drive_en <= 1'b0;
      wdata_q  <= {DATA_WIDTH{1'b0}};
    end else begin
      // done is a single-cycle pulse unless a completing state re-arms it.
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            // Strobes are loaded together with the state so they are
            // already valid during the first cycle of the command.
            ram_cs   <= 1'b1;
            ram_addr <= addr;
            if (wr) begin
              state    <= WR;
              ram_we   <= 1'b1;
              ram_oe   <= 1'b0;
              drive_en <= 1'b1;
              wdata_q  <= wdata;
            end else begin
              state    <= RD_ISSUE;
              ram_we   <= 1'b0;
              ram_oe   <= 1'b1;
              drive_en <= 1'b0;
            end
          end else begin
            state    <= IDLE;
            ram_cs   <= 1'b0;
            ram_we   <= 1'b0;
            ram_oe   <= 1'b0;
            drive_en <= 1'b0;
          end
        end
        WR: begin
          // The RAM latches the word at this edge; release bus and strobes.
          state    <= IDLE;
          ram_cs   <= 1'b0;
          ram_we   <= 1'b0;
          ram_oe   <= 1'b0;
          drive_en <= 1'b0;
          done     <= 1'b1;
        end
        RD_ISSUE: begin
          // Whatever the RAM shows here is stale; it registers mem[addr] now.
          state <= RD_CAPT;
        end
        RD_CAPT: begin
          rdata  <= ram_data;
          done   <= 1'b1;
          ram_cs <= 1'b0;
          ram_we <= 1'b0;
          ram_oe <= 1'b0;
`ifdef RAM_BUS_MASTER_TURNAROUND_EN
          state  <= TURN;
`else
          state  <= IDLE;
`endif
        end
`ifdef RAM_BUS_MASTER_TURNAROUND_EN
        TURN: begin
          // Dead bus cycle so the RAM output driver is fully off.
          state <= IDLE;
        end
`endif
        default: begin
          state    <= IDLE;
          ram_cs   <= 1'b0;
          ram_we   <= 1'b0;
          ram_oe   <= 1'b0;
          drive_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_bus_master.sv
// tb_ram_bus_master: randomized self-checking bench for ram_bus_master with
// a behavioural synchronous RAM on the shared bus and a flat array model of
// the expected memory contents.
module tb_ram_bus_master;

  logic       clock;
  logic       reset;
  logic       req;
  logic       ready;
  logic       wr;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       done;
  logic       ram_cs;
  logic       ram_we;
  logic       ram_oe;
  logic [7:0] ram_addr;
  wire  [7:0] ram_data;

  int n_cmp;
  int n_err;

  logic [7:0] exp_mem [256];
  logic [7:0] ram_mem [256];
  logic [7:0] ram_q;

`ifdef RAM_BUS_MASTER_TURNAROUND_EN
  localparam int READ_SPACING = 4;
  localparam bit READY_AT_DONE = 1'b0;
`else
  localparam int READ_SPACING = 3;
  localparam bit READY_AT_DONE = 1'b1;
`endif

  ram_bus_master #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clock    (clock),
    .reset    (reset),
    .req      (req),
    .ready    (ready),
    .wr       (wr),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .done     (done),
    .ram_cs   (ram_cs),
    .ram_we   (ram_we),
    .ram_oe   (ram_oe),
    .ram_addr (ram_addr),
    .ram_data (ram_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural RAM: synchronous write, registered read, drives the bus when
  // selected for reading.
  always @(posedge clock) begin
    if (ram_cs && ram_we) ram_mem[ram_addr] <= ram_data;
    if (ram_cs && !ram_we) ram_q <= ram_mem[ram_addr];
  end
  assign ram_data = (ram_cs && ram_oe && !ram_we) ? ram_q : 8'bz;

  // All driving and sampling happen on falling edges; tasks start and end there.
  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL wr_ready_pre: got %b want 1", ready); end
    req = 1'b1; wr = 1'b1; addr = a; wdata = d;
    @(negedge clock);
    req = 1'b0; wdata = $urandom;
    n_cmp++; if (ram_cs !== 1'b1) begin n_err++; $display("FAIL wr_cs: got %b want 1", ram_cs); end
    n_cmp++; if (ram_we !== 1'b1) begin n_err++; $display("FAIL wr_we: got %b want 1", ram_we); end
    n_cmp++; if (ram_oe !== 1'b0) begin n_err++; $display("FAIL wr_oe: got %b want 0", ram_oe); end
    n_cmp++; if (ram_addr !== a) begin n_err++; $display("FAIL wr_addr: got %h want %h", ram_addr, a); end
    n_cmp++; if (ram_data !== d) begin n_err++; $display("FAIL wr_bus: got %h want %h", ram_data, d); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL wr_done_early: got %b want 0", done); end
    n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL wr_busy: got %b want 0", ready); end
    exp_mem[a] = d;
    @(negedge clock);
    n_cmp++; if (ram_cs !== 1'b0 || ram_we !== 1'b0) begin n_err++; $display("FAIL wr_strobe_len: got cs=%b we=%b want 0 0", ram_cs, ram_we); end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL wr_done: got %b want 1", done); end
    n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL wr_ready_post: got %b want 1", ready); end
    n_cmp++; if (ram_mem[a] !== exp_mem[a]) begin n_err++; $display("FAIL wr_mem[%h]: got %h want %h", a, ram_mem[a], exp_mem[a]); end
  endtask

  task automatic do_read(input logic [7:0] a);
    n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL rd_ready_pre: got %b want 1", ready); end
    req = 1'b1; wr = 1'b0; addr = a; wdata = $urandom;
    @(negedge clock);
    req = 1'b0;
    n_cmp++; if (ram_cs !== 1'b1 || ram_oe !== 1'b1 || ram_we !== 1'b0) begin n_err++; $display("FAIL rd_issue_strobes: got cs=%b oe=%b we=%b want 1 1 0", ram_cs, ram_oe, ram_we); end
    n_cmp++; if (ram_addr !== a) begin n_err++; $display("FAIL rd_addr: got %h want %h", ram_addr, a); end
    n_cmp++; if (ready !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL rd_issue_hs: got ready=%b done=%b want 0 0", ready, done); end
    @(negedge clock);
    n_cmp++; if (ram_cs !== 1'b1 || ram_oe !== 1'b1 || ram_we !== 1'b0) begin n_err++; $display("FAIL rd_capt_strobes: got cs=%b oe=%b we=%b want 1 1 0", ram_cs, ram_oe, ram_we); end
    n_cmp++; if (ram_data !== exp_mem[a]) begin n_err++; $display("FAIL rd_bus: got %h want %h", ram_data, exp_mem[a]); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rd_done_early: got %b want 0", done); end
    @(negedge clock);
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL rd_done: got %b want 1", done); end
    n_cmp++; if (rdata !== exp_mem[a]) begin n_err++; $display("FAIL rd_data[%h]: got %h want %h", a, rdata, exp_mem[a]); end
    n_cmp++; if (ram_cs !== 1'b0 || ram_oe !== 1'b0) begin n_err++; $display("FAIL rd_release: got cs=%b oe=%b want 0 0", ram_cs, ram_oe); end
    n_cmp++; if (ready !== READY_AT_DONE) begin n_err++; $display("FAIL rd_ready_at_done: got %b want %b", ready, READY_AT_DONE); end
`ifdef RAM_BUS_MASTER_TURNAROUND_EN
    @(negedge clock);
    n_cmp++; if (ready !== 1'b1 || done !== 1'b0 || ram_cs !== 1'b0) begin n_err++; $display("FAIL rd_turn: got ready=%b done=%b cs=%b want 1 0 0", ready, done, ram_cs); end
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 1'b0; wr = 1'b0; addr = 8'h00; wdata = 8'h00;
    repeat (3) @(negedge clock);
    n_cmp++; if (ram_cs !== 1'b0 || ram_we !== 1'b0 || ram_oe !== 1'b0) begin n_err++; $display("FAIL rst_strobes: got %b%b%b want 000", ram_cs, ram_we, ram_oe); end
    n_cmp++; if (ram_addr !== 8'h00 || rdata !== 8'h00) begin n_err++; $display("FAIL rst_regs: got addr=%h rdata=%h want 00 00", ram_addr, rdata); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b want 0", done); end
    reset = 1'b0;
    @(negedge clock);
    n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", ready); end
  endtask

  task automatic test_write_read();
    do_write(8'h10, 8'hA5);
    do_write(8'hFF, 8'h3C);
    do_read(8'hFF);
    do_read(8'h10);
  endtask

  task automatic test_back_to_back();
    int acc[$];
    logic [7:0] got[$];
    do_write(8'h00, 8'($urandom));
    do_write(8'h01, 8'($urandom));
    req = 1'b1; wr = 1'b0; addr = 8'h00;
    for (int c = 0; c < 16; c++) begin
      if (req && ready) acc.push_back(c);
      @(negedge clock);
      if (done) got.push_back(rdata);
      if (acc.size() == 1) addr = 8'h01;
      if (acc.size() == 2) req = 1'b0;
    end
    n_cmp++; if (acc.size() !== 2) begin n_err++; $display("FAIL b2b_accepts: got %0d want 2", acc.size()); end
    if (acc.size() == 2) begin
      n_cmp++; if (acc[1] - acc[0] !== READ_SPACING) begin n_err++; $display("FAIL b2b_spacing: got %0d want %0d", acc[1] - acc[0], READ_SPACING); end
    end
    n_cmp++; if (got.size() !== 2) begin n_err++; $display("FAIL b2b_dones: got %0d want 2", got.size()); end
    if (got.size() == 2) begin
      n_cmp++; if (got[0] !== exp_mem[0] || got[1] !== exp_mem[1]) begin n_err++; $display("FAIL b2b_rdata: got %h %h want %h %h", got[0], got[1], exp_mem[0], exp_mem[1]); end
    end
  endtask

  task automatic test_req_while_busy();
    int cs_cnt;
    int we_cnt;
    int done_cnt;
    do_write(8'h20, 8'($urandom));
    do_write(8'h21, 8'($urandom));
    req = 1'b1; wr = 1'b0; addr = 8'h20;
    @(negedge clock);
    // Still requesting, now a write, while the read is in flight.
    wr = 1'b1; addr = 8'h21; wdata = ~exp_mem[8'h21];
    cs_cnt = int'(ram_cs); we_cnt = int'(ram_we); done_cnt = int'(done);
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      req = 1'b0;
      cs_cnt += int'(ram_cs); we_cnt += int'(ram_we); done_cnt += int'(done);
    end
    n_cmp++; if (cs_cnt !== 2) begin n_err++; $display("FAIL busy_cs_cycles: got %0d want 2", cs_cnt); end
    n_cmp++; if (we_cnt !== 0) begin n_err++; $display("FAIL busy_we_cycles: got %0d want 0", we_cnt); end
    n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL busy_dones: got %0d want 1", done_cnt); end
    n_cmp++; if (rdata !== exp_mem[8'h20]) begin n_err++; $display("FAIL busy_rdata: got %h want %h", rdata, exp_mem[8'h20]); end
    n_cmp++; if (ram_mem[8'h21] !== exp_mem[8'h21]) begin n_err++; $display("FAIL busy_mem: got %h want %h", ram_mem[8'h21], exp_mem[8'h21]); end
  endtask

  task automatic test_reset_mid_wr();
    int done_cnt;
    do_write(8'h40, 8'h5A);
    @(negedge clock);
    req = 1'b1; wr = 1'b1; addr = 8'h40; wdata = 8'hA5;
    @(posedge clock);
    #2;
    n_cmp++; if (ram_cs !== 1'b1 || ram_we !== 1'b1) begin n_err++; $display("FAIL arst_pre: got cs=%b we=%b want 1 1", ram_cs, ram_we); end
    reset = 1'b1;
    #1;
    n_cmp++; if (ram_cs !== 1'b0 || ram_we !== 1'b0 || ram_oe !== 1'b0) begin n_err++; $display("FAIL arst_strobes: got %b%b%b want 000", ram_cs, ram_we, ram_oe); end
    n_cmp++; if (ram_addr !== 8'h00 || rdata !== 8'h00 || done !== 1'b0) begin n_err++; $display("FAIL arst_regs: got addr=%h rdata=%h done=%b want 00 00 0", ram_addr, rdata, done); end
    @(negedge clock);
    req = 1'b0; reset = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      done_cnt += int'(done);
    end
    n_cmp++; if (done_cnt !== 0) begin n_err++; $display("FAIL arst_done: got %0d want 0", done_cnt); end
    n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL arst_ready: got %b want 1", ready); end
    n_cmp++; if (ram_mem[8'h40] !== exp_mem[8'h40]) begin n_err++; $display("FAIL arst_mem: got %h want %h", ram_mem[8'h40], exp_mem[8'h40]); end
    do_read(8'h40);
  endtask

  task automatic test_overwrite();
    do_write(8'h80, 8'h00);
    do_write(8'h80, 8'hFF);
    do_read(8'h80);
  endtask

  task automatic test_random();
    logic [7:0] a;
    for (int i = 0; i < 16; i++) do_write(8'(i), 8'($urandom));
    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) do_write(a, 8'($urandom));
      else do_read(a);
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_req_while_busy();
    test_reset_mid_wr();
    test_overwrite();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
